fir_serial_mac: RTL

- Time-multiplexed (serial) FIR engine that sits directly downstream of the coefficient ROM.
- Per input sample it: stores the sample in a delay line, drives the ROM address from 0 to Num_coef-1, consumes the coefficient returned one cycle later, and accumulates one product per cycle.
- Emits one filtered output sample per input sample, with a single-cycle valid strobe.
- One multiplier, one accumulator.

---
 rtl/fir_pkg.sv | 23 ++
 rtl/fir_delay_line.sv | 34 +++
 rtl/fir_serial_mac.sv | 134 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared widths and FSM encoding for the serial FIR engine and its coefficient ROM.
package fir_pkg;

  // Address width for a memory of n words; a single-word memory still gets one bit.
  function automatic int clog2_ceil(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int acc_width(input int win, input int wc, input int ncoef);
    return win + wc + clog2_ceil(ncoef);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

endpackage

// File: rtl/fir_delay_line.sv
// Sample shift register for the serial FIR; the tap selected by rd_idx_i is
// registered so it lines up with the one-cycle ROM read latency.
module fir_delay_line #(
  parameter int Num_coef = 17,
  parameter int Win      = 16,
  parameter int Aw       = 5
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           shift_en_i,
  input  logic [Win-1:0] x_i,
  input  logic [Aw-1:0]  rd_idx_i,
  output logic [Win-1:0] d_o
);

  logic [Win-1:0] taps_q [Num_coef];
  logic [Win-1:0] d_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < Num_coef; i++) taps_q[i] <= '0;
      d_q <= '0;
    end else begin
      if (shift_en_i) begin
        taps_q[0] <= x_i;
        for (int i = 1; i < Num_coef; i++) taps_q[i] <= taps_q[i-1];
      end
      d_q <= taps_q[rd_idx_i];
    end
  end

  assign d_o = d_q;

endmodule

// File: rtl/fir_serial_mac.sv
// Serial single-multiplier FIR: one output per accepted sample, Num_coef+2 cycles later.
// Build option FIR_SAT_EN clamps the scaled result to the output range instead of wrapping.
//
// state    | meaning
// ST_IDLE  | ready high, waiting for x_valid
// ST_MAC   | walk coef_addr 0..Num_coef-1, accumulate from the second cycle
// ST_FLUSH | accumulate the last tap product
// ST_OUT   | register y_out and raise y_valid
module fir_serial_mac
  import fir_pkg::*;
#(
  parameter  int Wc       = 18,
  parameter  int Num_coef = 17,
  parameter  int Win      = 16,
  parameter  int Wout     = 16,
  localparam int Aw       = clog2_ceil(Num_coef)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic signed [Win-1:0]  x_in,
  input  logic                   x_valid,
  output logic                   ready,
  output logic [Aw-1:0]          coef_addr,
  input  logic signed [Wc-1:0]   coef_data,
  output logic signed [Wout-1:0] y_out,
  output logic                   y_valid
);

  localparam int Wprod = Win + Wc;
  localparam int Wacc  = acc_width(Win, Wc, Num_coef);
  localparam logic [Aw-1:0] KLast = Aw'(Num_coef - 1);

  state_e                 state_q, state_d;
  logic [Aw-1:0]          k_q, k_d;
  logic signed [Wacc-1:0] acc_q, acc_d;
  logic signed [Wout-1:0] y_q, y_d;
  logic                   yv_q, yv_d;
  logic                   accept;
  logic                   acc_en;
  logic [Win-1:0]         d_al;
  logic signed [Wprod-1:0] prod;
  logic signed [Wacc-1:0] prod_ext;
  logic signed [Wout-1:0] y_fmt;

  assign accept = (state_q == ST_IDLE) && x_valid;

  fir_delay_line #(
    .Num_coef (Num_coef),
    .Win      (Win),
    .Aw       (Aw)
  ) u_delay_line (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .shift_en_i (accept),
    .x_i        (x_in),
    .rd_idx_i   (k_q),
    .d_o        (d_al)
  );

  assign prod     = $signed(d_al) * coef_data;
  assign prod_ext = {{(Wacc - Wprod){prod[Wprod-1]}}, prod};

`ifdef FIR_SAT_EN
  localparam logic signed [Wacc-1:0] YMax = {{(Wacc - Wout + 1){1'b0}}, {(Wout - 1){1'b1}}};
  localparam logic signed [Wacc-1:0] YMin = {{(Wacc - Wout + 1){1'b1}}, {(Wout - 1){1'b0}}};
  logic signed [Wacc-1:0] scaled;

  assign scaled = acc_q >>> (Wc - 1);

  always_comb begin
    if (scaled > YMax)      y_fmt = YMax[Wout-1:0];
    else if (scaled < YMin) y_fmt = YMin[Wout-1:0];
    else                    y_fmt = scaled[Wout-1:0];
  end
`else
  // Wrapping output is just a bit slice of the accumulator.
  assign y_fmt = acc_q[Wc-1 +: Wout];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (x_valid) state_d = ST_MAC;
      ST_MAC:   if (k_q == KLast) state_d = ST_FLUSH;
      ST_FLUSH: state_d = ST_OUT;
      ST_OUT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    k_d    = k_q;
    acc_d  = acc_q;
    y_d    = y_q;
    yv_d   = 1'b0;
    // First MAC cycle only primes the ROM and alignment register.
    acc_en = ((state_q == ST_MAC) && (k_q != '0)) || (state_q == ST_FLUSH);
    if (accept) begin
      k_d   = '0;
      acc_d = '0;
    end
    if ((state_q == ST_MAC) && (k_q != KLast)) k_d = k_q + Aw'(1);
    if (acc_en) acc_d = acc_q + prod_ext;
    if (state_q == ST_OUT) begin
      y_d  = y_fmt;
      yv_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q   <= '0;
      acc_q <= '0;
      y_q   <= '0;
      yv_q  <= 1'b0;
    end else begin
      k_q   <= k_d;
      acc_q <= acc_d;
      y_q   <= y_d;
      yv_q  <= yv_d;
    end
  end

  assign ready     = (state_q == ST_IDLE);
  assign coef_addr = k_q;
  assign y_out     = y_q;
  assign y_valid   = yv_q;

endmodule
